// File: rtl/la_fifowrarb_pkg.sv
// Shared definitions for the packet-aware FIFO write arbiter and its
// round-robin picker.
package la_fifowrarb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Source-ID width; a single requester still needs one ID bit.
  function automatic int calc_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/la_rrpick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward modulo N over a doubled request vector.
module la_rrpick
  import la_fifowrarb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = calc_idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] winner
);

  logic [2*N-1:0] dbl;
  logic           found;
  int             idx;

  assign dbl = {req, req};
  assign any = |req;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && dbl[int'(ptr) + i]) begin
        found = 1'b1;
        idx   = int'(ptr) + i;
        // Fold the doubled position back onto a requester index.
        if (idx >= N) idx = idx - N;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/la_fifowrarb.sv
// Packet-aware round-robin arbiter sharing one FIFO write port among N
// requesters; a winner keeps the port until its last beat is written.
module la_fifowrarb
  import la_fifowrarb_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int DW  = 32,
  localparam int IDW = calc_idw(N)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              clear,
  input  logic [N-1:0]      req_valid,
  input  logic [N*DW-1:0]   req_data,
  input  logic [N-1:0]      req_last,
  output logic [N-1:0]      req_ready,
  output logic              fifo_wr_en,
  output logic [IDW+DW-1:0] fifo_wr_din,
  input  logic              fifo_wr_full,
  output logic [IDW-1:0]    grant_id,
  output logic              busy
);

  // Handshake: a beat transfers in any cycle where req_valid[i] and
  // req_ready[i] are both high; ready never depends on anything but the
  // grant, fifo_wr_full and clear, and the FIFO write happens that cycle.

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;

  logic           pick_any;
  logic [IDW-1:0] pick_winner;
  logic           sel_valid;
  logic           sel_last;
  logic [DW-1:0]  sel_data;
  logic           accept;

  la_rrpick #(.N(N), .IDW(IDW)) u_rrpick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .any    (pick_any),
    .winner (pick_winner)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_id_q == IDW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DW +: DW];
      end
    end
  end

  // Clear abandons the packet in the same cycle, so it gates the handshake.
  assign accept = (state_q == LOCK) && !clear && sel_valid && !fifo_wr_full;

  always_comb begin
    req_ready = '0;
    if (state_q == LOCK && !clear) begin
      for (int i = 0; i < N; i++) begin
        if (grant_id_q == IDW'(i)) req_ready[i] = !fifo_wr_full;
      end
    end
  end

  assign fifo_wr_en  = accept;
  assign fifo_wr_din = {grant_id_q, sel_data};
  assign grant_id    = grant_id_q;
  assign busy        = (state_q == LOCK);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    if (clear) begin
      state_d    = IDLE;
      rr_ptr_d   = '0;
      grant_id_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_id_d = pick_winner;
            state_d    = LOCK;
          end
        end
        LOCK: begin
          if (accept && sel_last) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_id_q == IDW'(N-1)) ? '0 : grant_id_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

endmodule
